wave_sel_sequencer: RTL and testbench
=====================================

Name: wave_sel_sequencer

Overview:
Controller for the DDS output waveform selector. It owns the 3-bit select that picks sine, saw, pulse, triangle or noise. Select changes are applied only on a phase-accumulator wrap, so waveform switches never produce a mid-period discontinuity. The block has two modes: manual, where a host requests a waveform through a valid/ready handshake, and auto-cycle, where the block steps through all waveforms every programmable number of periods.

Parameters:
NUM_WAVES, 5, number of valid select codes (0..NUM_WAVES-1); codes at or above this value are invalid.
SEL_W, 3, select width.
CNT_W, 8, width of the period (wrap) counter and the dwell input.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
phase_wrap  input  1  single-cycle pulse from the phase accumulator on overflow.
req_valid  input  1  host has a select request.
req_sel  input  SEL_W  requested waveform code.
req_ready  output  1  block can accept a request this cycle.
auto_en  input  1  level; 1 selects auto-cycle mode.
dwell  input  CNT_W  periods per waveform in auto mode; 0 is treated as 1.
sel  output  SEL_W  registered select driven to the waveform mux.
pending  output  1  a manual request is latched and waiting for a wrap.
switch_pulse  output  1  one-cycle pulse in the cycle after sel changes value.

Behaviour:
- Reset (asynchronous):
  - state=HOLD, sel=0 (sine), pending_sel=0, wrap_cnt=0.
  - pending=0, switch_pulse=0, req_ready=1 (only if auto_en=0 after release).
  - Any latched request is discarded.
- States:
  - HOLD: sel is static.
  - PEND: a request is latched and the block waits for phase_wrap.
  - AUTO: the block counts wraps and cycles sel.
- req_ready is combinational: 1 only when state=HOLD and auto_en=0. It is 0 in PEND and AUTO.
- Handshake acceptance: a request is accepted on a clock edge where req_valid and req_ready are both 1.
  - pending_sel <= req_sel if req_sel < NUM_WAVES, else 0.
  - state -> PEND, pending=1.
  - req_sel is sampled only on the accept edge.
- HOLD -> PEND with no effective change: if the accepted code equals the current sel, the block still goes to PEND and waits for a wrap. sel does not change, and switch_pulse is NOT raised.
- PEND:
  - On the first phase_wrap edge after acceptance: sel <= pending_sel, pending=0, state -> HOLD.
  - switch_pulse=1 for exactly one cycle if the value changed.
  - A phase_wrap coinciding with the accept edge does not apply the change; the next wrap does.
  - Latency from accept to sel update is therefore at least one full period, one cycle after the applying wrap edge.
- auto_en:
  - Sampled only in HOLD. HOLD with auto_en=1 -> AUTO, wrap_cnt=0.
  - auto_en is ignored in PEND until that request completes, then HOLD immediately moves to AUTO if auto_en is still 1.
- AUTO, on each phase_wrap:
  - If wrap_cnt >= max(dwell,1)-1: sel <= (sel==NUM_WAVES-1) ? 0 : sel+1, wrap_cnt=0, switch_pulse for one cycle.
  - Otherwise wrap_cnt increments, saturating at all-ones.
  - dwell is compared live. Lowering dwell below the current count advances the waveform on the next wrap.
- auto_en falling while in AUTO:
  - Next edge -> HOLD with sel unchanged and wrap_cnt=0.
  - If phase_wrap coincides with that edge, the wrap is ignored and no advance happens.
- Outputs sel, pending and switch_pulse are registered; no combinational path from phase_wrap to sel.

Test Plan:
1. Reset values: assert rst mid-operation, from PEND with pending_sel=3 -> sel=0, pending=0, switch_pulse=0 asynchronously; after release with auto_en=0, req_ready=1 and the old request is never applied.
2. Manual switch: in HOLD, present req_valid=1, req_sel=2 -> accepted, pending=1, req_ready=0; sel stays 0 through arbitrary cycles; on phase_wrap, sel=2 on the next cycle, one-cycle switch_pulse, pending=0, req_ready=1.
3. Wrap/accept collision and invalid code: accept req_sel=6 on the same edge as phase_wrap -> no change on that wrap; the next wrap gives sel=0; switch_pulse=0 if sel was already 0, and a one-cycle pulse if not.
4. Auto cycle: auto_en=1, dwell=3, start sel=0 -> sel sequence 1,2,3,4,0 advancing every 3rd wrap; switch_pulse on each advance; req_ready=0 throughout.
5. dwell=0 and live change: dwell=0 advances on every wrap. With dwell=10 and wrap_cnt=5, set dwell=2 -> advance on the next wrap, then every 2 wraps.
6. Mode exit/entry: drop auto_en at sel=3 coincident with phase_wrap -> HOLD, sel stays 3. Raise auto_en while in PEND -> request completes first, then AUTO entered with wrap_cnt=0.

Source files
------------

// File: rtl/wave_sel_sequencer.sv
// DDS waveform select controller: holds the waveform select code and applies
// changes only on phase-accumulator wraps, in manual (handshake) or auto-cycle mode.
module wave_sel_sequencer #(
   parameter int NUM_WAVES = 5,
   parameter int SEL_W     = 3,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             phase_wrap,
   input  logic             req_valid,
   input  logic [SEL_W-1:0] req_sel,
   output logic             req_ready,
   input  logic             auto_en,
   input  logic [CNT_W-1:0] dwell,
   output logic [SEL_W-1:0] sel,
   output logic             pending,
   output logic             switch_pulse
);

   typedef enum logic [1:0] {
      S_HOLD,
      S_PEND,
      S_AUTO
   } state_e;

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_WAVES - 1);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] psel_q, psel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             pulse_q, pulse_d;

   logic             accept;
   logic [CNT_W-1:0] dwell_last;
   logic [CNT_W-1:0] cnt_inc;
   logic [SEL_W-1:0] next_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_HOLD;
         sel_q     <= '0;
         psel_q    <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         psel_q    <= psel_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         pulse_q   <= pulse_d;
      end
   end

   // A dwell of 0 behaves as 1, so the advance threshold bottoms out at 0.
   assign dwell_last = (dwell == '0) ? '0 : dwell - CNT_W'(1);
   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   assign next_sel   = (sel_q >= LAST_SEL) ? '0 : sel_q + SEL_W'(1);
   assign accept     = req_valid && req_ready;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      psel_d    = psel_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      pulse_d   = 1'b0;
      case (state_q)
         S_HOLD: begin
            if (auto_en) begin
               state_d = S_AUTO;
               cnt_d   = '0;
            end else if (accept) begin
               state_d   = S_PEND;
               pending_d = 1'b1;
               psel_d    = (req_sel <= LAST_SEL) ? req_sel : '0;
            end
         end
         S_PEND: begin
            if (phase_wrap) begin
               state_d   = S_HOLD;
               pending_d = 1'b0;
               sel_d     = psel_q;
               pulse_d   = (psel_q != sel_q);
            end
         end
         S_AUTO: begin
            // Leaving auto mode takes priority over a coincident wrap.
            if (!auto_en) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else if (phase_wrap) begin
               if (cnt_q >= dwell_last) begin
                  sel_d   = next_sel;
                  cnt_d   = '0;
                  pulse_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = S_HOLD;
         end
      endcase
   end

   always_comb begin
      req_ready    = (state_q == S_HOLD) && !auto_en;
      sel          = sel_q;
      pending      = pending_q;
      switch_pulse = pulse_q;
   end

   a_sel_valid : assert property (@(posedge clk) disable iff (rst) sel_q <= LAST_SEL);
   a_pend_state : assert property (@(posedge clk) disable iff (rst)
      pending_q == (state_q == S_PEND));

endmodule

// File: tb/tb_wave_sel_sequencer.sv
// Bench for wave_sel_sequencer: directed scenarios plus random traffic, all
// compared cycle by cycle against a period-counting behavioural model.
module tb_wave_sel_sequencer;

   localparam int NUM_WAVES = 5;
   localparam int SEL_W     = 3;
   localparam int CNT_W     = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             phase_wrap = 1'b0;
   logic             req_valid = 1'b0;
   logic [SEL_W-1:0] req_sel = '0;
   logic             req_ready;
   logic             auto_en = 1'b0;
   logic [CNT_W-1:0] dwell = '0;
   logic [SEL_W-1:0] sel;
   logic             pending;
   logic             switch_pulse;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: mode flags plus a count of wraps seen in the current dwell.
   int m_sel   = 0;
   int m_psel  = 0;
   int m_wraps = 0;
   bit m_pend  = 0;
   bit m_auto  = 0;
   bit m_pulse = 0;

   wave_sel_sequencer #(
      .NUM_WAVES(NUM_WAVES),
      .SEL_W    (SEL_W),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .phase_wrap  (phase_wrap),
      .req_valid   (req_valid),
      .req_sel     (req_sel),
      .req_ready   (req_ready),
      .auto_en     (auto_en),
      .dwell       (dwell),
      .sel         (sel),
      .pending     (pending),
      .switch_pulse(switch_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic model_reset();
      m_sel = 0; m_psel = 0; m_wraps = 0;
      m_pend = 0; m_auto = 0; m_pulse = 0;
   endtask

   task automatic model_edge(input bit w, input bit v, input int s, input bit a, input int d);
      int eff;
      eff = (d == 0) ? 1 : d;
      m_pulse = 0;
      if (m_pend) begin
         if (w) begin
            m_pulse = (m_psel != m_sel);
            m_sel   = m_psel;
            m_pend  = 0;
         end
      end else if (m_auto) begin
         if (!a) begin
            m_auto  = 0;
            m_wraps = 0;
         end else if (w) begin
            m_wraps++;
            if (m_wraps >= eff) begin
               m_sel   = (m_sel + 1) % NUM_WAVES;
               m_wraps = 0;
               m_pulse = 1;
            end
         end
      end else if (a) begin
         m_auto  = 1;
         m_wraps = 0;
      end else if (v) begin
         m_pend = 1;
         m_psel = (s < NUM_WAVES) ? s : 0;
      end
   endtask

   task automatic check_outputs(input string phase);
      chk({phase, ".sel"}, int'(sel), m_sel);
      chk({phase, ".pending"}, int'(pending), int'(m_pend));
      chk({phase, ".switch_pulse"}, int'(switch_pulse), int'(m_pulse));
      chk({phase, ".req_ready"}, int'(req_ready), int'(!m_pend && !m_auto && !auto_en));
   endtask

   task automatic cycle(input string phase, input bit w, input bit v, input int s,
                        input bit a, input int d);
      @(negedge clk);
      phase_wrap = w;
      req_valid  = v;
      req_sel    = SEL_W'(s);
      auto_en    = a;
      dwell      = CNT_W'(d);
      @(posedge clk);
      model_edge(w, v, s, a, d);
      #1;
      check_outputs(phase);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("rst.sel_async", int'(sel), 0);
      chk("rst.pending_async", int'(pending), 0);
      chk("rst.pulse_async", int'(switch_pulse), 0);
      @(posedge clk);
      @(negedge clk);
      phase_wrap = 1'b0; req_valid = 1'b0; req_sel = '0; auto_en = 1'b0; dwell = '0;
      rst = 1'b0;
      #1;
      chk("rst.req_ready", int'(req_ready), 1);
   endtask

   initial begin
      bit a_r;
      int d_r;
      do_reset();

      // Reset while a request for code 3 is pending: it must never be applied.
      cycle("t1.acc", 0, 1, 3, 0, 0);
      chk("t1.pending", int'(pending), 1);
      do_reset();
      for (int i = 0; i < 3; i++) cycle("t1.wrap", 1, 0, 0, 0, 0);
      chk("t1.sel_stays0", int'(sel), 0);

      // Manual switch to 2; req_sel changes after accept must be ignored.
      cycle("t2.acc", 0, 1, 2, 0, 0);
      for (int i = 0; i < 3; i++) cycle("t2.wait", 0, 1, 4, 0, 0);
      cycle("t2.apply", 1, 0, 0, 0, 0);
      chk("t2.sel", int'(sel), 2);
      chk("t2.pulse", int'(switch_pulse), 1);
      cycle("t2.after", 0, 0, 0, 0, 0);
      chk("t2.pulse_end", int'(switch_pulse), 0);

      // Invalid code accepted on a wrap edge: applied as 0 on the next wrap.
      cycle("t3.acc", 1, 1, 6, 0, 0);
      cycle("t3.idle", 0, 0, 0, 0, 0);
      cycle("t3.apply", 1, 0, 0, 0, 0);
      chk("t3.sel0", int'(sel), 0);
      cycle("t3.acc2", 1, 1, 7, 0, 0);
      cycle("t3.apply2", 1, 0, 0, 0, 0);
      chk("t3.nopulse", int'(switch_pulse), 0);

      // Auto cycling every 3rd wrap: five advances return to 0.
      cycle("t4.enter", 1, 0, 0, 1, 3);
      for (int i = 0; i < 15; i++) begin
         cycle("t4.gap", 0, 1, 1, 1, 3);
         cycle("t4.wrap", 1, 1, 1, 1, 3);
      end
      chk("t4.sel_wrapped", int'(sel), 0);

      // dwell 0 advances every wrap; then lower dwell below the live count.
      for (int i = 0; i < 5; i++) cycle("t5.d0", 1, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) cycle("t5.d10", 1, 0, 0, 1, 10);
      cycle("t5.lower", 1, 0, 0, 1, 2);
      chk("t5.lower_pulse", int'(switch_pulse), 1);
      for (int i = 0; i < 4; i++) cycle("t5.d2", 1, 0, 0, 1, 2);

      // Step to sel 3, then drop auto_en on a wrap edge.
      for (int i = 0; i < 8 && m_sel != 3; i++) cycle("t6.step", 1, 0, 0, 1, 1);
      cycle("t6.exit", 1, 0, 0, 0, 1);
      chk("t6.sel_held", int'(sel), 3);
      cycle("t6.acc", 0, 1, 1, 0, 0);
      cycle("t6.auto_in_pend", 0, 0, 0, 1, 2);
      cycle("t6.apply", 1, 0, 0, 1, 2);
      chk("t6.sel_applied", int'(sel), 1);
      cycle("t6.to_auto", 1, 0, 0, 1, 2);
      cycle("t6.cnt1", 1, 0, 0, 1, 2);
      chk("t6.no_early_adv", int'(sel), 1);
      cycle("t6.cnt2", 1, 0, 0, 1, 2);
      chk("t6.adv", int'(sel), 2);

      // Random traffic.
      a_r = 0;
      d_r = 2;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 39) == 0) a_r = !a_r;
         if ($urandom_range(0, 29) == 0) d_r = $urandom_range(0, 4);
         cycle("rnd", ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 7), a_r, d_r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
